// File: rtl/fir_serial_mac_if.sv
// Sample/coefficient/result bundle for fir_serial_mac.
// master = sample and coefficient source, slave = the filter.
interface fir_serial_mac_if #(
  parameter int unsigned TAPS = 16
);
  logic                      data_valid;
  logic signed [15:0]        data_in;
  logic                      in_ready;
  logic                      coef_we;
  logic [$clog2(TAPS)-1:0]   coef_addr;
  logic signed [15:0]        coef_data;
  logic                      fir_valid;
  logic signed [15:0]        fir_d;

  modport master (
    output data_valid, data_in, coef_we, coef_addr, coef_data,
    input  in_ready, fir_valid, fir_d
  );

  modport slave (
    input  data_valid, data_in, coef_we, coef_addr, coef_data,
    output in_ready, fir_valid, fir_d
  );
endinterface

// File: rtl/fir_serial_mac.sv
// Single-MAC time-multiplexed FIR: one sample in, TAPS multiply-accumulate cycles, one result out.
// Define FIR_SAT_EN to saturate the rounded result to 16 bits instead of wrapping it.
module fir_serial_mac #(
  parameter int unsigned TAPS      = 16,
  parameter int unsigned COEF_FRAC = 15
) (
  input logic              clk,
  input logic              rst,
  fir_serial_mac_if.slave  bus
);
  localparam int unsigned IdxW = $clog2(TAPS);
  localparam int unsigned AccW = 32 + IdxW;

  localparam logic signed [AccW-1:0] RndBias = {{(AccW-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                 state_q, state_d;
  logic signed [15:0]     x_q [TAPS];
  logic signed [15:0]     c_q [TAPS];
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic signed [15:0]     fir_d_q, fir_d_d;
  logic                   fir_valid_q, fir_valid_d;

  logic                   accept;
  logic                   coef_wr;
  logic signed [31:0]     prod;
  logic signed [AccW-1:0] rounded;
  logic signed [15:0]     narrow;

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.fir_valid = fir_valid_q;
  assign bus.fir_d     = fir_d_q;

  assign accept  = bus.data_valid && (state_q == StIdle);
  // An accept in the same cycle wins over a coefficient write.
  assign coef_wr = bus.coef_we && (state_q == StIdle) && !accept &&
                   (32'(bus.coef_addr) < TAPS);

  assign prod    = x_q[idx_q] * c_q[idx_q];
  assign rounded = (acc_q + RndBias) >>> COEF_FRAC;

`ifdef FIR_SAT_EN
  localparam logic signed [AccW-1:0] SatMax = AccW'(32767);
  localparam logic signed [AccW-1:0] SatMin = AccW'(-32768);

  always_comb begin
    if (rounded > SatMax) begin
      narrow = 16'sh7fff;
    end else if (rounded < SatMin) begin
      narrow = 16'sh8000;
    end else begin
      narrow = rounded[15:0];
    end
  end
`else
  assign narrow = rounded[15:0];
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    fir_d_d     = fir_d_q;
    fir_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + AccW'(prod);
        if (idx_q == IdxW'(TAPS - 1)) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        fir_d_d     = narrow;
        fir_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      idx_q       <= '0;
      fir_d_q     <= '0;
      fir_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      fir_d_q     <= fir_d_d;
      fir_valid_q <= fir_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        x_q[0] <= bus.data_in;
        for (int i = 1; i < TAPS; i++) begin
          x_q[i] <= x_q[i-1];
        end
      end
      if (coef_wr) begin
        c_q[bus.coef_addr] <= bus.coef_data;
      end
    end
  end
endmodule
